// File: rtl/ssd_pkg.sv
// ssd_pkg: segment glyphs, scan FSM states and sizing helper for the seven-segment scanner.
package ssd_pkg;
    localparam logic [7:0] SSD_0    = 8'b0000_0011;
    localparam logic [7:0] SSD_1    = 8'b1001_1111;
    localparam logic [7:0] SSD_2    = 8'b0010_0101;
    localparam logic [7:0] SSD_3    = 8'b0000_1101;
    localparam logic [7:0] SSD_4    = 8'b1001_1001;
    localparam logic [7:0] SSD_5    = 8'b0100_1001;
    localparam logic [7:0] SSD_6    = 8'b0100_0001;
    localparam logic [7:0] SSD_7    = 8'b0001_1111;
    localparam logic [7:0] SSD_8    = 8'b0000_0001;
    localparam logic [7:0] SSD_9    = 8'b0000_1001;
    localparam logic [7:0] SSD_A    = 8'b0001_0001;
    localparam logic [7:0] SSD_B    = 8'b1100_0001;
    localparam logic [7:0] SSD_C    = 8'b0110_0011;
    localparam logic [7:0] SSD_D    = 8'b1000_0101;
    localparam logic [7:0] SSD_E    = 8'b0110_0001;
    localparam logic [7:0] SSD_F    = 8'b0111_0001;
    localparam logic [7:0] SSD_DASH = 8'b1111_1101;
    localparam logic [7:0] SSD_OFF  = 8'hFF;

    typedef enum logic {BLANK, SCAN} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ssd_scan_ctl_if.sv
// ssd_scan_ctl_if: display data in / scanned segment and anode pins out.
interface ssd_scan_ctl_if
    import ssd_pkg::*;
#(parameter int N_DIGITS = 4);
    logic                          en;
    logic [4*N_DIGITS-1:0]         bcd_in;
    logic [N_DIGITS-1:0]           dp_in;
    logic                          blank_lead;
    logic [7:0]                    ssd_seg;
    logic [N_DIGITS-1:0]           ssd_an;
    logic [idx_w(N_DIGITS)-1:0]    digit_idx;
    logic                          frame_tick;

    modport master (output en, bcd_in, dp_in, blank_lead,
                    input  ssd_seg, ssd_an, digit_idx, frame_tick);
    modport slave  (input  en, bcd_in, dp_in, blank_lead,
                    output ssd_seg, ssd_an, digit_idx, frame_tick);
endinterface

// File: rtl/ssd_scan_ctl_bcd_to_ssd.sv
// bcd_to_ssd: 4-bit code to active-low segments {a..g,dp}, with optional digit blanking.
module bcd_to_ssd
    import ssd_pkg::*;
#(parameter bit HEX_MODE = 1'b1)
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    logic [7:0] glyph;

    always_comb begin
        case (code)
            4'h0: glyph = SSD_0;
            4'h1: glyph = SSD_1;
            4'h2: glyph = SSD_2;
            4'h3: glyph = SSD_3;
            4'h4: glyph = SSD_4;
            4'h5: glyph = SSD_5;
            4'h6: glyph = SSD_6;
            4'h7: glyph = SSD_7;
            4'h8: glyph = SSD_8;
            4'h9: glyph = SSD_9;
            4'hA: glyph = HEX_MODE ? SSD_A : SSD_DASH;
            4'hB: glyph = HEX_MODE ? SSD_B : SSD_DASH;
            4'hC: glyph = HEX_MODE ? SSD_C : SSD_DASH;
            4'hD: glyph = HEX_MODE ? SSD_D : SSD_DASH;
            4'hE: glyph = HEX_MODE ? SSD_E : SSD_DASH;
            default: glyph = HEX_MODE ? SSD_F : SSD_DASH;
        endcase
        // every glyph has its dp bit high, so masking bit 0 applies the requested point
        seg = (blank ? SSD_OFF : glyph) & {7'h7F, ~dp};
    end
endmodule

// File: rtl/ssd_scan_ctl.sv
// ssd_scan_ctl: prescaled one-digit-at-a-time scanner with per-frame snapshot and
// leading-zero suppression for a common-anode multi-digit display.
module ssd_scan_ctl
    import ssd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 100000,
    parameter bit HEX_MODE = 1'b1
)
(
    input  logic clk,
    input  logic rst,
    ssd_scan_ctl_if.slave bus
);
    localparam int W  = idx_w(N_DIGITS);
    localparam int CW = $clog2(SCAN_DIV);

    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic [W-1:0]          idx, idx_n;
    logic [4*N_DIGITS-1:0] frame_bcd, bcd_n;
    logic [N_DIGITS-1:0]   frame_dp, dp_n, lz;
    logic                  tick, wrap, snap, z;
    logic [7:0]            seg_n;

    // outputs are decoded from next-cycle state so they land together with the new idx
    always_comb begin
        tick    = bus.en && cnt == CW'(SCAN_DIV - 1);
        wrap    = state == BLANK || idx == W'(N_DIGITS - 1);
        snap    = tick && wrap;
        state_n = !bus.en ? BLANK : tick ? SCAN : state;
        idx_n   = !bus.en ? '0 : tick ? (wrap ? '0 : idx + W'(1)) : idx;
        bcd_n   = snap ? bus.bcd_in : frame_bcd;
        dp_n    = snap ? bus.dp_in : frame_dp;
        z       = 1'b1;
        lz      = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            z     = z && bcd_n[4*k +: 4] == 4'd0;
            lz[k] = z && k != 0 && bus.blank_lead;
        end
    end

    bcd_to_ssd #(.HEX_MODE(HEX_MODE)) u_dec (
        .code  (bcd_n[4*idx_n +: 4]),
        .dp    (dp_n[idx_n]),
        .blank (lz[idx_n]),
        .seg   (seg_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= BLANK;
            cnt            <= '0;
            idx            <= '0;
            frame_bcd      <= '0;
            frame_dp       <= '0;
            bus.ssd_seg    <= SSD_OFF;
            bus.ssd_an     <= '1;
            bus.digit_idx  <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= (!bus.en || tick) ? '0 : cnt + CW'(1);
            idx            <= idx_n;
            frame_bcd      <= bcd_n;
            frame_dp       <= dp_n;
            bus.ssd_seg    <= state_n == SCAN ? seg_n : SSD_OFF;
            bus.ssd_an     <= state_n == SCAN ? ~(N_DIGITS'(1) << idx_n) : '1;
            bus.digit_idx  <= idx_n;
            bus.frame_tick <= snap;
        end
    end
endmodule

// File: tb/tb_ssd_scan_ctl.sv
// tb_ssd_scan_ctl: directed scan sequence with a per-slot scoreboard, checking a hex build
// and a dash build side by side.
module tb_ssd_scan_ctl;
    localparam int SD = 4;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic [7:0] seg0;
        logic [1:0] idx;
        logic       ft;
    } exp_t;

    logic clk, rst;
    int   checks = 0, errors = 0;
    exp_t q[$];

    ssd_scan_ctl_if #(.N_DIGITS(4)) bus ();
    ssd_scan_ctl_if #(.N_DIGITS(4)) bus0 ();

    assign bus0.en         = bus.en;
    assign bus0.bcd_in     = bus.bcd_in;
    assign bus0.dp_in      = bus.dp_in;
    assign bus0.blank_lead = bus.blank_lead;

    ssd_scan_ctl #(.N_DIGITS(4), .SCAN_DIV(SD), .HEX_MODE(1'b1)) dut (
        .clk (clk), .rst (rst), .bus (bus));
    ssd_scan_ctl #(.N_DIGITS(4), .SCAN_DIV(SD), .HEX_MODE(1'b0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [7:0] glyph(input logic [3:0] c, input bit hex);
        logic [7:0] t [16];
        t = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        return (c > 4'd9 && !hex) ? 8'hFD : t[c];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] b, input logic [3:0] d, input bit bl, input int n);
        exp_t e;
        bit   zr, blk;
        for (int k = 0; k < n; k++) begin
            zr = 1'b1;
            for (int j = k; j < 4; j++) zr = zr && b[4*j +: 4] == 4'd0;
            blk    = bl && k > 0 && zr;
            e.an   = ~(4'b0001 << k);
            e.seg  = {blk ? 7'h7F : glyph(b[4*k +: 4], 1'b1) >> 1, ~d[k]};
            e.seg0 = {blk ? 7'h7F : glyph(b[4*k +: 4], 1'b0) >> 1, ~d[k]};
            e.idx  = 2'(k);
            e.ft   = k == 0;
            q.push_back(e);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) begin
            $display("FAIL scoreboard_empty");
            $fatal(1);
        end
        e = q.pop_front();
        check("an", bus.ssd_an, e.an);
        check("seg", bus.ssd_seg, e.seg);
        check("idx", bus.digit_idx, e.idx);
        check("frame_tick", bus.frame_tick, e.ft);
        check("seg_dash_build", bus0.ssd_seg, e.seg0);
    endtask

    task automatic run_slot();
        for (int i = 0; i < SD - 1; i++) begin
            @(posedge clk); @(negedge clk);
            check("mid_slot_tick", bus.frame_tick, 0);
        end
        @(posedge clk); @(negedge clk);
        pop_check();
    endtask

    task automatic check_off(input string tag);
        check({tag, "_an"}, bus.ssd_an, 4'hF);
        check({tag, "_seg"}, bus.ssd_seg, 8'hFF);
        check({tag, "_idx"}, bus.digit_idx, 0);
        check({tag, "_tick"}, bus.frame_tick, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        bus.bcd_in = 16'h1234;
        bus.dp_in = 4'b0000;
        bus.blank_lead = 1'b0;
        #1 check_off("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_frame(16'h1234, 4'b0000, 1'b0, 4);
        for (int i = 0; i < SD - 1; i++) begin
            @(posedge clk); @(negedge clk);
            check_off("pre_frame");
        end
        @(posedge clk); @(negedge clk);
        pop_check();
        run_slot();
        run_slot();
        // digit 2 on screen: new data must wait for the next frame
        bus.bcd_in = 16'h5678;
        push_frame(16'h5678, 4'b0000, 1'b0, 4);
        repeat (5) run_slot();
        bus.bcd_in = 16'h0070;
        bus.dp_in = 4'b1000;
        bus.blank_lead = 1'b1;
        push_frame(16'h0070, 4'b1000, 1'b1, 4);
        repeat (4) run_slot();
        bus.blank_lead = 1'b0;
        push_frame(16'h0070, 4'b1000, 1'b0, 4);
        repeat (4) run_slot();
        bus.bcd_in = 16'hABCF;
        bus.dp_in = 4'b0000;
        push_frame(16'hABCF, 4'b0000, 1'b0, 4);
        repeat (4) run_slot();
        push_frame(16'hABCF, 4'b0000, 1'b0, 2);
        repeat (2) run_slot();
        bus.en = 1'b0;
        @(posedge clk); @(negedge clk);
        check_off("en_drop");
        bus.bcd_in = 16'h9876;
        bus.en = 1'b1;
        push_frame(16'h9876, 4'b0000, 1'b0, 4);
        repeat (4) run_slot();
        push_frame(16'h9876, 4'b0000, 1'b0, 1);
        run_slot();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_off("async_rst");
        @(negedge clk);
        rst = 1'b0;
        bus.dp_in = 4'b0101;
        push_frame(16'h9876, 4'b0101, 1'b0, 4);
        repeat (4) run_slot();
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
